// File: rtl/button_debouncer_if.sv
// Push-button pin and the debounced event outputs it produces, grouped as one bundle.
// The master drives the raw pin; the slave (the debouncer) drives the results.
interface button_debouncer_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_press_pulse, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_press_pulse, press_count
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces a raw push-button and emits press, release and long-press strobes
// together with a wrapping count of accepted presses.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  button_debouncer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [31:0] DB_LAST = DEBOUNCE_CYCLES - 1;
  localparam logic [31:0] LP_LAST = LONG_PRESS_CYCLES - 1;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        fired_q, fired_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic [7:0]  count_q, count_d;
  logic        btn_norm;
  logic        sync;

  // Normalise polarity before synchronising so 1 always means pressed.
  assign btn_norm = bus.btn_in ^ ACTIVE_LOW;
  assign sync     = sync_q[1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      fired_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], btn_norm};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      fired_q   <= fired_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (sync) state_d = PRESS_WAIT;
      PRESS_WAIT:   if (!sync) state_d = IDLE;
                    else if (cnt_q == DB_LAST) state_d = PRESSED;
      PRESSED:      if (!sync) state_d = RELEASE_WAIT;
      RELEASE_WAIT: if (sync) state_d = PRESSED;
                    else if (cnt_q == DB_LAST) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    fired_d   = fired_q;
    level_d   = level_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: cnt_d = '0;
      PRESS_WAIT: begin
        if (!sync) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
          fired_d = 1'b0;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESSED: begin
        // The hold count stops once the long press has fired so it cannot refire.
        if (!sync) begin
          cnt_d = '0;
        end else if (hold_q == LP_LAST && !fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end else if (!fired_q) begin
          hold_d = hold_q + 32'd1;
        end
      end
      RELEASE_WAIT: begin
        if (!sync) begin
          if (cnt_q == DB_LAST) begin
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.btn_level        = level_q;
  assign bus.press_pulse      = press_q;
  assign bus.release_pulse    = release_q;
  assign bus.long_press_pulse = long_q;
  assign bus.press_count      = count_q;

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles needed to accept a press or release (10 ms at 100 MHz); legal range 2 to 2^32-1.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 100000000, cycles from press_pulse to long_press_pulse (1 s at 100 MHz); legal range 2 to 2^32-1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means btn_in low = pressed, 0 means btn_in high = pressed.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing push-button pin.
REQ-007 btn_level  output  1  debounced state; 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe when a press is accepted.
REQ-009 release_pulse  output  1  one-cycle strobe when a release is accepted.
REQ-010 long_press_pulse  output  1  one-cycle strobe when a press has been held LONG_PRESS_CYCLES.
REQ-011 press_count  output  8  number of accepted presses since reset, modulo 256.

Function
REQ-012 btn_in SHALL be normalized so that 1 = pressed (XOR with ACTIVE_LOW), then passed through a 2-flop synchronizer; only the second flop output (sync) feeds the rest of the logic.
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. It uses a 32-bit debounce counter (cnt) and a 32-bit hold counter (hold).
REQ-015 IDLE: sync=1 -> PRESS_WAIT with cnt=0; otherwise stay.
REQ-016 PRESS_WAIT transitions:
- sync=0 -> IDLE, cnt=0, no pulse (bounce rejected).
- else cnt=DEBOUNCE_CYCLES-1 -> PRESSED; btn_level=1, press_pulse=1, hold=0, long-fired flag cleared, press_count incremented.
- else cnt increments.
REQ-017 PRESSED transitions:
- sync=0 -> RELEASE_WAIT, cnt=0.
- else hold=LONG_PRESS_CYCLES-1 and flag clear -> long_press_pulse=1, flag set.
- else, if flag clear, hold increments.
REQ-018 RELEASE_WAIT transitions:
- sync=1 -> PRESSED; hold and flag are kept; no press_pulse; press_count unchanged.
- else cnt=DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0, release_pulse=1.
- else cnt increments; hold frozen.
REQ-019 Latency: for a clean input, press_pulse SHALL rise on the (DEBOUNCE_CYCLES+2)-th rising edge after the first edge that samples btn_in pressed. release_pulse has the same latency from release.
REQ-020 long_press_pulse SHALL assert exactly LONG_PRESS_CYCLES cycles after press_pulse when the press is held continuously. It fires at most once per accepted press.
REQ-021 Each pulse output SHALL be high for exactly one cycle. press_pulse and release_pulse are never high in the same cycle.
REQ-022 press_count SHALL wrap from 255 to 0 without any flag.
REQ-023 btn_level SHALL change only in the same cycle as press_pulse or release_pulse.

Reset
REQ-024 While rst_in=1, all of the following SHALL be forced immediately, independent of clk_in:
- synchronizer flops = 0
- state = IDLE
- cnt = 0, hold = 0, flag clear
- btn_level = 0, press_count = 0, all pulses = 0
REQ-025 After rst_in deasserts with the button already held, the block SHALL run a full debounce and then issue press_pulse; the held state is not assumed.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=0 unless stated)
REQ-026 Clean press: btn_in 0->1, first sampled at edge 1, held -> press_pulse and btn_level=1 at edge 7; long_press_pulse at edge 17 only; press_count=1.
REQ-027 Bounce: btn_in high for 2 cycles, low, high for 3 cycles, then low for good -> no pulses at all; btn_level=0; press_count=0.
REQ-028 Release glitch: while pressed, drop btn_in for 2 cycles then restore -> no release_pulse, no second press_pulse; long_press_pulse still fires exactly once.
REQ-029 Reset mid-press: assert rst_in in PRESSED with btn_in held -> outputs 0 before the next clock edge; after deassert, press_pulse again after 6 edges; press_count=1.
REQ-030 Wrap and polarity: with ACTIVE_LOW=1, apply 256 clean low-going presses and releases -> 256 press_pulses and 256 release_pulses; press_count ends at 0.
